// File: rtl/live_generator_mc.sv
// live_generator_mc
//   Multi-channel, run-time configurable liveness/heartbeat generator.
//   Each of NCH channels runs a counter 0..period-1 and produces a square,
//   inverted-square or pulse heartbeat plus a one-cycle tick at every wrap.
//   Configuration writes are held per channel and take effect at the next
//   wrap so period changes never glitch the outputs. A global sync restarts
//   every counter and applies all held writes at once.
//
//   Optional feature: define HB_WATCHDOG_EN to add a per-channel watchdog
//   that monitors external heartbeats (hb_in) and raises hb_lost when no
//   rising edge is seen for WD_LIMIT cycles.
//
// Ports
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   sync        in   1       synchronous restart of all channel counters
//   cfg_we      in   1       configuration write strobe
//   cfg_ch      in   CH_W    target channel (>= NCH is ignored)
//   cfg_period  in   CNT_W   new period in clk cycles
//   cfg_mode    in   2       00 off, 01 square, 10 pulse, 11 inverted square
//   q           out  NCH     per-channel heartbeat, registered
//   tick        out  NCH     per-channel 1-cycle wrap pulse, registered
//   hb_in       in   NCH     monitored heartbeats (HB_WATCHDOG_EN only)
//   hb_lost     out  NCH     watchdog expired flags (HB_WATCHDOG_EN only)
module live_generator_mc #(
    parameter int              NCH        = 4,
    parameter int              CNT_W      = 30,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 30'h2000_0000,
    parameter int              CH_W       = 4
`ifdef HB_WATCHDOG_EN
    ,
    parameter logic [31:0]     WD_LIMIT   = 32'd1000000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [1:0]       cfg_mode,
    output logic [NCH-1:0]   q,
    output logic [NCH-1:0]   tick
`ifdef HB_WATCHDOG_EN
    ,
    input  logic [NCH-1:0]   hb_in,
    output logic [NCH-1:0]   hb_lost
`endif
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SQ    = 2'b01;
    localparam logic [1:0] MODE_PULSE = 2'b10;
    localparam logic [1:0] MODE_INV   = 2'b11;

    logic [CNT_W-1:0] cnt         [NCH];
    logic [CNT_W-1:0] period      [NCH];
    logic [1:0]       mode        [NCH];
    logic [CNT_W-1:0] pend_period [NCH];
    logic [1:0]       pend_mode   [NCH];
    logic [NCH-1:0]   pend_vld;

    logic [CNT_W-1:0] ld_period   [NCH];
    logic [1:0]       ld_mode     [NCH];
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   wrap;
    logic [NCH-1:0]   wr;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   sq;
    logic [NCH-1:0]   tick_nxt;
    logic [NCH-1:0]   q_nxt;

    // High for the upper half of the period; odd periods give the low
    // phase the extra cycle (period 5 -> high for cnt 3,4).
    function automatic logic square(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] p);
        return c >= (p - (p >> 1));
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            en[i]       = (mode[i] != MODE_OFF) && (period[i] >= CNT_W'(2));
            wrap[i]     = en[i] && (cnt[i] == period[i] - CNT_W'(1));
            wr[i]       = cfg_we && (cfg_ch == CH_W'(i));
            // A disabled channel reloads every cycle, so writes to it land
            // immediately; a running one reloads only at wrap or sync.
            load[i]     = sync || wrap[i] || !en[i];
            sq[i]       = square(cnt[i], period[i]);
            tick_nxt[i] = wrap[i] && !sync;

            // A write in the load cycle itself beats an older held value.
            ld_period[i] = period[i];
            ld_mode[i]   = mode[i];
            if (wr[i]) begin
                ld_period[i] = cfg_period;
                ld_mode[i]   = cfg_mode;
            end else if (pend_vld[i]) begin
                ld_period[i] = pend_period[i];
                ld_mode[i]   = pend_mode[i];
            end

            q_nxt[i] = 1'b0;
            if (en[i]) begin
                case (mode[i])
                    MODE_SQ:    q_nxt[i] = sq[i];
                    MODE_INV:   q_nxt[i] = ~sq[i];
                    MODE_PULSE: q_nxt[i] = tick_nxt[i];
                    default:    q_nxt[i] = 1'b0;
                endcase
            end
        end
    end

    // Counter / config state and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]         <= '0;
                period[i]      <= DEF_PERIOD;
                mode[i]        <= MODE_SQ;
                pend_period[i] <= '0;
                pend_mode[i]   <= MODE_OFF;
            end
            pend_vld <= '0;
            q        <= '0;
            tick     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    cnt[i]      <= '0;
                    period[i]   <= ld_period[i];
                    mode[i]     <= ld_mode[i];
                    pend_vld[i] <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                    if (wr[i]) begin
                        pend_period[i] <= cfg_period;
                        pend_mode[i]   <= cfg_mode;
                        pend_vld[i]    <= 1'b1;
                    end
                end
                q[i]    <= q_nxt[i];
                tick[i] <= tick_nxt[i];
            end
        end
    end

`ifdef HB_WATCHDOG_EN
    logic [NCH-1:0] hb_prev;
    logic [31:0]    wd_cnt [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_prev <= '0;
            hb_lost <= '0;
            for (int i = 0; i < NCH; i++) begin
                wd_cnt[i] <= '0;
            end
        end else begin
            hb_prev <= hb_in;
            for (int i = 0; i < NCH; i++) begin
                if (mode[i] == MODE_OFF) begin
                    wd_cnt[i]  <= '0;
                    hb_lost[i] <= 1'b0;
                end else if (hb_in[i] && !hb_prev[i]) begin
                    wd_cnt[i]  <= '0;
                    hb_lost[i] <= 1'b0;
                end else if (wd_cnt[i] != WD_LIMIT) begin
                    // Saturate at the limit; hb_lost rises with the count
                    // reaching it and then holds until the next edge.
                    wd_cnt[i] <= wd_cnt[i] + 32'd1;
                    if (wd_cnt[i] + 32'd1 == WD_LIMIT) begin
                        hb_lost[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    // No watchdog in this build: hb_in/hb_lost do not exist.
`endif

endmodule

// File: tb/tb_live_generator_mc.sv
module tb_live_generator_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = 4'd0;
    logic [29:0] cfg_period = 30'd0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [3:0]  q;
    logic [3:0]  tick;
`ifdef HB_WATCHDOG_EN
    logic [3:0]  hb_in = 4'h0;
    logic [3:0]  hb_lost;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    live_generator_mc #(
        .NCH(4),
        .CNT_W(30),
        .DEF_PERIOD(30'd8),
        .CH_W(4)
`ifdef HB_WATCHDOG_EN
        ,
        .WD_LIMIT(32'd20)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync(sync),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_mode(cfg_mode),
        .q(q),
        .tick(tick)
`ifdef HB_WATCHDOG_EN
        ,
        .hb_in(hb_in),
        .hb_lost(hb_lost)
`endif
    );

    typedef struct {
        logic        we;
        logic [3:0]  ch;
        logic [29:0] period;
        logic [1:0]  mode;
        logic [3:0]  exp_q;
        logic [3:0]  exp_tick;
    } vec_t;

    vec_t tbl [16];

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [29:0] per, input logic [1:0] md);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        cfg_mode   = md;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows: inputs driven during cycle r, outputs expected after edge r+1.
        tbl[0]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[2]  = '{1'b1, 4'd4, 30'd3, 2'b11, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[4]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[5]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[6]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[7]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'hF};
        tbl[8]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[10] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'h0, 4'h0};
        tbl[12] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[13] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[14] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'h0};
        tbl[15] = '{1'b0, 4'd0, 30'd0, 2'b00, 4'hF, 4'hF};

        // Reset state and period-8 default waveform.
        do_reset();
        chk4("rst_q", q, 4'h0);
        chk4("rst_tick", tick, 4'h0);
`ifdef HB_WATCHDOG_EN
        chk4("rst_hb_lost", hb_lost, 4'h0);
`endif
        for (int r = 0; r < 16; r++) begin
            cfg_we     = tbl[r].we;
            cfg_ch     = tbl[r].ch;
            cfg_period = tbl[r].period;
            cfg_mode   = tbl[r].mode;
            step();
            cfg_we = 1'b0;
            chk4("tbl_q", q, tbl[r].exp_q);
            chk4("tbl_tick", tick, tbl[r].exp_tick);
        end
        // Asynchronous reset mid-cycle while q and tick are high.
        rst_n = 1'b0;
        #1;
        chk4("async_rst_q", q, 4'h0);
        chk4("async_rst_tick", tick, 4'h0);
`ifdef HB_WATCHDOG_EN
        chk4("async_rst_hb_lost", hb_lost, 4'h0);
`endif

        // ch1 -> period 5 pulse mode, written mid-period.
        do_reset();
        repeat (3) step();
        wr(4'd1, 30'd5, 2'b10);
        while (cyc <= 23) begin
            logic et;
            et = (cyc == 8) || (cyc == 13) || (cyc == 18) || (cyc == 23);
            chk1("s2_tick1", tick[1], et);
            chk1("s2_q1", q[1], ((cyc >= 5) && (cyc <= 8)) || ((cyc >= 9) && et));
            chk1("s2_tick0", tick[0], (cyc % 8) == 0);
            step();
        end

        // ch0 square / ch2 inverted square at period 6, then ch2 period 1.
        do_reset();
        wr(4'd0, 30'd6, 2'b01);
        wr(4'd2, 30'd6, 2'b11);
        while (cyc < 9) step();
        while (cyc < 20) begin
            chk1("s3_q0", q[0], ((cyc - 9) % 6) >= 3);
            chk1("s3_q2", q[2], !(((cyc - 9) % 6) >= 3));
            step();
        end
        wr(4'd2, 30'd1, 2'b11);
        while (cyc <= 35) begin
            chk1("s3_tick2", tick[2], cyc == 26);
            chk1("s3_q2_dis", q[2], (cyc <= 26) ? !(((cyc - 9) % 6) >= 3) : 1'b0);
            step();
        end

        // Phase-offset ch3, then sync during the other channels' wrap cycle.
        do_reset();
        wr(4'd3, 30'd8, 2'b00);
        while (cyc < 10) begin
            chk1("s4_q3_a", q[3], (cyc <= 8) ? (((cyc - 1) % 8) >= 4) : 1'b0);
            chk4("s4_tick_a", tick, (cyc == 8) ? 4'hF : 4'h0);
            step();
        end
        wr(4'd3, 30'd8, 2'b01);
        while (cyc < 22) begin
            chk4("s4_tick_b", tick, {cyc == 19, (cyc == 16) ? 3'b111 : 3'b000});
            chk1("s4_q3_b", q[3], (cyc >= 12) ? (((cyc - 12) % 8) >= 4) : 1'b0);
            step();
        end
        wr(4'd3, 30'd4, 2'b01);
        sync = 1'b1;
        step();
        sync = 1'b0;
        while (cyc <= 32) begin
            chk4("s4_tick_sync", tick,
                 {(cyc == 28) || (cyc == 32), (cyc == 32) ? 3'b111 : 3'b000});
            if (cyc >= 25) begin
                chk4("s4_q_sync", q,
                     {((cyc - 25) % 4) >= 2, (cyc >= 29) ? 3'b111 : 3'b000});
            end
            step();
        end

        // Write in the wrap cycle, two writes before a wrap, out-of-range channel.
        do_reset();
        step();
        step();
        wr(4'd1, 30'd3, 2'b10);
        wr(4'd1, 30'd6, 2'b10);
        while (cyc < 7) step();
        wr(4'd0, 30'd4, 2'b01);
        chk4("s5_tick8", tick, 4'hF);
        step();
        wr(4'd4, 30'd2, 2'b00);
        while (cyc <= 20) begin
            logic t0, t1, t23;
            t0  = (cyc == 12) || (cyc == 16) || (cyc == 20);
            t1  = (cyc == 14) || (cyc == 20);
            t23 = (cyc == 16);
            chk4("s5_tick", tick, {t23, t23, t1, t0});
            chk1("s5_q1", q[1], t1);
            chk1("s5_q0", q[0], ((cyc - 9) % 4) >= 2);
            step();
        end

`ifdef HB_WATCHDOG_EN
        // Watchdog with WD_LIMIT = 20.
        begin
            int last;
            int r;
            do_reset();
            last = 0;
            for (int p = 0; p < 4; p++) begin
                hb_in = 4'hF;
                last  = cyc;
                step();
                hb_in = 4'h0;
                repeat (9) begin
                    chk4("wd_alive", hb_lost, 4'h0);
                    step();
                end
            end
            while (cyc <= last + 25) begin
                chk4("wd_lost", hb_lost, (cyc >= last + 21) ? 4'hF : 4'h0);
                step();
            end
            hb_in = 4'hF;
            r = cyc;
            step();
            hb_in = 4'h0;
            chk4("wd_resume", hb_lost, 4'h0);
            chk1("wd_resume_cyc", cyc == r + 1, 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
